// File: rtl/dma_tagged_copy_engine.sv
// rtl/dma_tagged_copy_engine.sv - multi-line tagged DMA copy engine with out-of-order read completion
module dma_tagged_copy_engine #(
  parameter int ADDR_W    = 42,
  parameter int DATA_W    = 512,
  parameter int LEN_W     = 32,
  parameter int MAX_OUTST = 32,
  parameter int BUF_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            src_addr,
  input  logic [ADDR_W-1:0]            dst_addr,
  input  logic [LEN_W-1:0]             len,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [LEN_W-1:0]             lines_written,
  output logic                         rd_req_valid,
  output logic [ADDR_W-1:0]            rd_req_addr,
  output logic [$clog2(MAX_OUTST)-1:0] rd_req_tag,
  input  logic                         rd_almfull,
  input  logic                         rd_rsp_valid,
  input  logic [$clog2(MAX_OUTST)-1:0] rd_rsp_tag,
  input  logic [DATA_W-1:0]            rd_rsp_data,
  output logic                         wr_req_valid,
  output logic [ADDR_W-1:0]            wr_req_addr,
  output logic [DATA_W-1:0]            wr_req_data,
  input  logic                         wr_almfull,
  input  logic                         wr_rsp_valid
);

  localparam int TAG_W  = $clog2(MAX_OUTST);
  localparam int CNT_W  = LEN_W + 1;
  localparam int OUT_W  = TAG_W + 1;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int CRD_W  = FCNT_W + 1;
  localparam int ENT_W  = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  acked_q;
  logic [CNT_W-1:0]  wr_outst_q;
  logic [OUT_W-1:0]  rd_outst_q;
  logic              aborted_q;

  logic [MAX_OUTST-1:0] free_q;
  logic [LEN_W-1:0]     slot_off [MAX_OUTST];

  logic [ENT_W-1:0]  fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;

  logic             free_any;
  logic [TAG_W-1:0] free_idx;
  logic             credit_ok;
  logic             start_ok;
  logic             issue_en;
  logic             rsp_hit;
  logic             push;
  logic             pop;
  logic             wr_ack;

  // Lowest-numbered free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        free_any = 1'b1;
        free_idx = TAG_W'(i);
      end
    end
  end

  // Issue/accept qualifiers. Every read in flight holds a FIFO credit, so the FIFO cannot overflow.
  always_comb begin
    credit_ok = (CRD_W'(rd_outst_q) + CRD_W'(fifo_cnt_q)) < CRD_W'(BUF_DEPTH);
    start_ok  = (state_q == S_IDLE) && start;
    issue_en  = (state_q == S_RUN) && !abort && (issued_q < len_q) && !rd_almfull &&
                free_any && credit_ok;
    rsp_hit   = rd_rsp_valid && !free_q[rd_rsp_tag];
    push      = rsp_hit && (state_q == S_RUN);
    pop       = (state_q == S_RUN) && (fifo_cnt_q != '0) && !wr_almfull;
    wr_ack    = wr_rsp_valid && (wr_outst_q != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; completion takes priority over an abort arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (acked_q == len_q) state_d = S_DONE;
        else if (abort)       state_d = S_DRAIN;
      end
      S_DRAIN: if ((rd_outst_q == '0) && (wr_outst_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    aborted = (state_q == S_DONE) && aborted_q;
  end

  assign lines_written = acked_q[LEN_W-1:0];

  // Transfer descriptor, progress counters and abort flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      wr_outst_q <= '0;
      rd_outst_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        src_q     <= src_addr;
        dst_q     <= dst_addr;
        len_q     <= {1'b0, len};
        issued_q  <= '0;
        acked_q   <= '0;
        aborted_q <= 1'b0;
      end else begin
        if (issue_en) issued_q <= issued_q + CNT_W'(1);
        if (wr_ack)   acked_q  <= acked_q + CNT_W'(1);
        if ((state_q == S_RUN) && (state_d == S_DRAIN)) aborted_q <= 1'b1;
      end
      rd_outst_q <= rd_outst_q + OUT_W'(issue_en) - OUT_W'(rsp_hit);
      wr_outst_q <= wr_outst_q + CNT_W'(pop) - CNT_W'(wr_ack);
    end
  end

  // Slot free-vector: issue claims a slot, a response to a busy slot releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= '1;
    end else begin
      if (issue_en) free_q[free_idx]   <= 1'b0;
      if (rsp_hit)  free_q[rd_rsp_tag] <= 1'b1;
    end
  end

  // Line offset remembered per slot so the response lands at dst + offset.
  always_ff @(posedge clk) begin
    if (issue_en) slot_off[free_idx] <= issued_q[LEN_W-1:0];
  end

  // Registered read request channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
    end else begin
      rd_req_valid <= issue_en;
      if (issue_en) begin
        rd_req_addr <= src_q + ADDR_W'(issued_q);
        rd_req_tag  <= free_idx;
      end
    end
  end

  // Write FIFO storage: each entry carries its final destination address.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr_q] <= {dst_q + ADDR_W'(slot_off[rd_rsp_tag]), rd_rsp_data};
  end

  // FIFO pointers; a new transfer or drain discards any leftover entries.
  always_ff @(posedge clk) begin
    if (reset || start_ok || (state_q == S_DRAIN)) begin
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      if (push) fifo_wr_ptr_q <= fifo_wr_ptr_q + PTR_W'(1);
      if (pop)  fifo_rd_ptr_q <= fifo_rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // Registered write request channel fed from the FIFO head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      wr_req_valid <= pop;
      if (pop) {wr_req_addr, wr_req_data} <= fifo_mem[fifo_rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_dma_tagged_copy_engine.sv
// tb/tb_dma_tagged_copy_engine.sv - randomized self-checking bench for dma_tagged_copy_engine
module tb_dma_tagged_copy_engine;

  localparam int ADDR_W    = 42;
  localparam int DATA_W    = 512;
  localparam int LEN_W     = 32;
  localparam int MAX_OUTST = 32;
  localparam int BUF_DEPTH = 64;
  localparam int TAG_W     = $clog2(MAX_OUTST);

  logic              clk, reset, start, abort;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done, aborted;
  logic [LEN_W-1:0]  lines_written;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_tag;
  logic              rd_almfull, rd_rsp_valid;
  logic [TAG_W-1:0]  rd_rsp_tag;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic              wr_almfull, wr_rsp_valid;

  dma_tagged_copy_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .MAX_OUTST(MAX_OUTST), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .lines_written(lines_written), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_tag(rd_req_tag), .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data), .wr_req_valid(wr_req_valid),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_almfull(wr_almfull),
    .wr_rsp_valid(wr_rsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Memory contents of a source line, derived from its address.
  function automatic logic [DATA_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < 16; k++)
      r[k*32 +: 32] = (a[31:0] ^ {22'd0, a[41:32]}) * 32'h9E3779B1 + 32'(k) * 32'h85EBCA6B;
    return r;
  endfunction

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  rd_t               pend[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  int                ack_pend;
  int                done_cnt;
  logic              last_aborted;
  logic [LEN_W-1:0]  last_lw;
  bit                rsp_hold, rsp_rand;
  int                rsp_order[$];
  logic [ADDR_W-1:0] cur_src;
  bit                post_abort;
  int                post_abort_reads;
  bit                late_go;
  logic [TAG_W-1:0]  late_tag;

  // Memory/channel model: records requests and returns responses on the falling edge.
  always @(negedge clk) begin
    int idx;
    if (reset) begin
      pend.delete();
      ack_pend     = 0;
      rd_rsp_valid = 1'b0;
      wr_rsp_valid = 1'b0;
    end else begin
      if (rd_req_valid) begin
        pend.push_back('{tag: rd_req_tag, addr: rd_req_addr});
        rd_log.push_back(rd_req_addr);
        if (post_abort) post_abort_reads++;
      end
      if (wr_req_valid) begin
        wr_addr_log.push_back(wr_req_addr);
        wr_data_log.push_back(wr_req_data);
        ack_pend++;
      end
      if (done) begin
        done_cnt++;
        last_aborted = aborted;
        last_lw      = lines_written;
      end
      wr_rsp_valid = 1'b0;
      if (ack_pend > 0 && $urandom_range(0, 3) != 0) begin
        wr_rsp_valid = 1'b1;
        ack_pend--;
      end
      rd_rsp_valid = 1'b0;
      if (late_go) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_tag   = late_tag;
        rd_rsp_data  = mkdata('0);
        late_go      = 1'b0;
      end else if (!rsp_hold && pend.size() > 0 && $urandom_range(0, 4) != 0) begin
        idx = -1;
        if (rsp_order.size() > 0) begin
          for (int k = 0; k < pend.size(); k++)
            if (pend[k].addr == cur_src + ADDR_W'(rsp_order[0])) idx = k;
        end else if (rsp_rand) begin
          idx = int'($urandom_range(0, pend.size() - 1));
        end else begin
          idx = 0;
        end
        if (idx >= 0) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_tag   = pend[idx].tag;
          rd_rsp_data  = mkdata(pend[idx].addr);
          if (rsp_order.size() > 0) void'(rsp_order.pop_front());
          pend.delete(idx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cnt         = 0;
    post_abort       = 1'b0;
    post_abort_reads = 0;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int l);
    clear_logs();
    cur_src  = s;
    src_addr = s;
    dst_addr = d;
    len      = LEN_W'(l);
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (done_cnt == 0) check({name, "_timeout"}, 64'd1, 64'd0);
    tick(4);
  endtask

  // Compare the copy against the reference: dst+i must hold the data of src+i, each line once.
  task automatic check_writes(input string name, input logic [ADDR_W-1:0] s,
                              input logic [ADDR_W-1:0] d, input int l);
    int bad = 0;
    int seen [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] off;
    for (int j = 0; j < wr_addr_log.size(); j++) begin
      off = wr_addr_log[j] - d;
      if (off >= ADDR_W'(l)) bad++;
      else if (wr_data_log[j] !== mkdata(s + off)) bad++;
      else if (seen.exists(wr_addr_log[j])) bad++;
      seen[wr_addr_log[j]] = 1;
    end
    check({name, "_wr_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic check_full(input string name, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input int l);
    int rbad = 0;
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_aborted"}, 64'(last_aborted), 64'd0);
    check({name, "_lw_at_done"}, 64'(last_lw), 64'(l));
    check({name, "_lw_hold"}, 64'(lines_written), 64'(l));
    check({name, "_rd_cnt"}, 64'(rd_log.size()), 64'(l));
    check({name, "_wr_cnt"}, 64'(wr_addr_log.size()), 64'(l));
    for (int i = 0; i < rd_log.size(); i++)
      if (rd_log[i] !== s + ADDR_W'(i)) rbad++;
    check({name, "_rd_addr_bad"}, 64'(rbad), 64'd0);
    check_writes(name, s, d, l);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] s, d;
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    rd_almfull = 1'b0; wr_almfull = 1'b0;
    rd_rsp_valid = 1'b0; rd_rsp_tag = '0; rd_rsp_data = '0; wr_rsp_valid = 1'b0;
    rsp_hold = 1'b0; rsp_rand = 1'b0; late_go = 1'b0; late_tag = '0;
    cur_src = '0; last_aborted = 1'b0; last_lw = '0; ack_pend = 0;
    clear_logs();
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_rd_req", 64'(rd_req_valid), 64'd0);
    check("rst_wr_req", 64'(wr_req_valid), 64'd0);
    check("rst_lw", 64'(lines_written), 64'd0);

    // Basic in-order copy.
    s = ADDR_W'({$urandom(), $urandom()}); d = ADDR_W'({$urandom(), $urandom()});
    start_xfer(s, d, 4);
    wait_done("len4", 2000);
    check_full("len4", s, d, 4);

    // Out-of-order responses; a second start while busy must be ignored.
    s = 42'h100; d = 42'h20000;
    rsp_order = '{7, 3, 0, 5, 1, 6, 2, 4};
    start_xfer(s, d, 8);
    tick(3);
    src_addr = 42'h999; len = 3; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("ooo8", 2000);
    check("ooo8_order_used", 64'(rsp_order.size()), 64'd0);
    check_full("ooo8", s, d, 8);

    // Withheld responses: issue stops once every slot is in flight.
    rsp_rand = 1'b1; rsp_hold = 1'b1;
    s = 42'h4000; d = 42'h9000;
    start_xfer(s, d, 100);
    tick(80);
    check("hold_rd_cnt", 64'(rd_log.size()), 64'(MAX_OUTST));
    check("hold_busy", 64'(busy), 64'd1);
    rsp_hold = 1'b0;
    wait_done("hold100", 5000);
    check_full("hold100", s, d, 100);

    // Write backpressure on a short transfer.
    wr_almfull = 1'b1;
    s = 42'h7000; d = 42'h7100;
    start_xfer(s, d, 16);
    tick(50);
    check("wbp16_no_wr", 64'(wr_addr_log.size()), 64'd0);
    check("wbp16_rd_cnt", 64'(rd_log.size()), 64'd16);
    wr_almfull = 1'b0;
    wait_done("wbp16", 2000);
    check_full("wbp16", s, d, 16);

    // Write backpressure on a long transfer: reads stop at exactly BUF_DEPTH credits.
    wr_almfull = 1'b1;
    s = 42'h5_0000; d = 42'h6_0000;
    start_xfer(s, d, 100);
    tick(300);
    check("credit_rd_cnt", 64'(rd_log.size()), 64'(BUF_DEPTH));
    wr_almfull = 1'b0;
    wait_done("credit100", 5000);
    check_full("credit100", s, d, 100);

    // Address wrap at the top of the address space, with random read backpressure.
    s = 42'h3FF_FFFF_FFFE; d = 42'h3FF_FFFF_FFFF;
    start_xfer(s, d, 5);
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      rd_almfull = ($urandom_range(0, 2) == 0);
      tick(1);
      n++;
    end
    rd_almfull = 1'b0;
    wait_done("wrap5", 2000);
    check_full("wrap5", s, d, 5);

    // Zero-length transfer completes with no traffic.
    start_xfer(42'h10, 42'h20, 0);
    wait_done("len0", 50);
    check_full("len0", 42'h10, 42'h20, 0);

    // Abort after at least 10 acknowledged writes.
    s = 42'hA_0000; d = 42'hB_0000;
    start_xfer(s, d, 64);
    n = 0;
    while (lines_written < 10 && n < 3000) begin
      tick(1);
      n++;
    end
    check("abort_reach10", 64'(lines_written >= 10), 64'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    post_abort = 1'b1;
    wait_done("abort64", 3000);
    check("abort_done_cnt", 64'(done_cnt), 64'd1);
    check("abort_flag", 64'(last_aborted), 64'd1);
    check("abort_new_reads", 64'(post_abort_reads), 64'd0);
    check("abort_lw_eq_writes", 64'(last_lw), 64'(wr_addr_log.size()));
    check("abort_lw_min", 64'(last_lw >= 10), 64'd1);
    check_writes("abort64", s, d, 64);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(4);
    check("abort_idle_ignored", 64'(done_cnt + 32'(busy)), 64'd1);

    // Reset mid-transfer, then a stale response, then a fresh transfer.
    rsp_hold = 1'b1;
    start_xfer(42'hC_0000, 42'hD_0000, 64);
    tick(10);
    check("rstmid_pending", 64'(pend.size() > 0), 64'd1);
    if (pend.size() > 0) late_tag = pend[0].tag;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_lw", 64'(lines_written), 64'd0);
    check("rstmid_rd_req", 64'(rd_req_valid), 64'd0);
    late_go = 1'b1;
    rsp_hold = 1'b0;
    tick(4);
    check("rstmid_no_done", 64'(done_cnt), 64'd0);
    check("rstmid_no_wr", 64'(wr_addr_log.size()), 64'd0);
    s = 42'hE_0000; d = 42'hF_0000;
    start_xfer(s, d, 2);
    wait_done("after_rst2", 1000);
    check_full("after_rst2", s, d, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
